id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the register file. Captures busX/busY plus
//  decoded fields, detects RAW hazards against older in-flight instructions, forwards results
//  from EX/MEM and MEM/WB, and holds or bubbles when EX back-pressures or a hazard is found.
//  Drives id_stall back to the IF/ID register and the PC.
// PARAMETERS
//  DW  32  operand / result width
//  AW  5   register index width (register 0 hardwired zero, never forwarded or hazarded)
// PORTS
//  Clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous, active-low reset
//  id_valid       in   1   ID holds a valid decoded instruction
//  id_rs, id_rt   in   AW  source indices (also drive register file RX/RY)
//  id_uses_rs/rt  in   1   instruction actually reads rs / rt
//  id_rd          in   AW  destination index
//  id_wen         in   1   instruction writes id_rd
//  id_is_load     in   1   instruction is a load (result available after MEM)
//  id_busX/busY   in   DW  operands from register file (WB bypass already applied there)
//  flush          in   1   branch redirect: kill instruction in ID
//  ex_ready       in   1   EX accepts ex_* this cycle
//  exmem_rd/wen   in   AW/1  EX/MEM destination and write enable
//  exmem_result   in   DW  EX/MEM ALU result
//  memwb_rd/wen   in   AW/1  MEM/WB destination and write enable
//  memwb_result   in   DW  MEM/WB writeback value
//  id_stall       out  1   hold IF/ID and PC (combinational)
//  ex_valid       out  1   ex_* fields valid
//  ex_opA/opB     out  DW  operands to EX, forwarded (combinational over stored values)
//  ex_rs/rt/rd    out  AW  stored indices
//  ex_wen, ex_is_load  out 1  stored control
//  stall_cnt      out  32  saturating count of cycles with id_stall=1
// BEHAVIOUR
//  Reset (rst=0 at posedge): ex_valid=0, stored opA/opB=0, ex_rs/rt/rd=0, ex_wen=0,
//   ex_is_load=0, stall_cnt=0. Reset mid-operation discards the held instruction.
//  hold = ex_valid & ~ex_ready.  adv = ~hold.
//  hazard_ld = ex_valid & ex_is_load & ex_wen & ex_rd!=0 &
//   ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
//  id_stall = ~flush & id_valid & (hold | hazard_ld [| hazard_nf, see CONFIG]).
//  On adv: if id_valid & ~id_stall & ~flush -> capture ID fields, ex_valid<=1;
//   else ex_valid<=0 and ex_wen<=0 (bubble). Latency ID->EX = 1 cycle.
//  On hold: ex_* indices/control unchanged; stored opA/opB <= forwarded ex_opA/ex_opB so the
//   value survives EX/MEM and MEM/WB moving on (refresh every hold cycle).
//  flush has priority over stall: ID instruction dropped; an instruction held in EX is older
//   and is NOT flushed.
//  Forwarding (per operand, src = ex_rs for A / ex_rt for B): src!=0 & exmem_wen &
//   exmem_rd==src -> exmem_result; else src!=0 & memwb_wen & memwb_rd==src -> memwb_result;
//   else stored value. EX/MEM wins when both match.
//  Load-use: exactly one bubble inserted; consumer then gets load data via MEM/WB forward.
//  stall_cnt increments each cycle id_stall=1, saturates at 32'hFFFFFFFF (no wrap).
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding as above; hazard_nf = 0.
//  Undefined: ex_opA/opB = stored values; refresh still uses stored (no change on hold);
//   hazard_nf = RAW match of used id_rs/id_rt (!=0) against (ex_valid & ex_wen & ex_rd) or
//   (exmem_wen & exmem_rd); id_stall held until both clear (WB covered by reg-file bypass).
// TESTING
//  Reset: rst=0 two cycles with id_valid=1 -> ex_valid=0, stall_cnt=0, ex_opA=0.
//  add r3 then sub r4,r3,r1 back-to-back, exmem_result=0x55 -> ex_opA=0x55, no stall (FWD_EN).
//  lw r5 in EX, next uses r5 -> id_stall=1 one cycle, bubble, then ex_opB=memwb_result=0xA5A5.
//  ex_ready=0 for 3 cycles while exmem forwards 0x77 to r2 source -> after release ex_opA=0x77.
//  flush=1 with hazard_ld=1 -> id_stall=0, next ex_valid=0; rd=r0 producer never forwarded.
//  FWD_EN off: add r3; use r3 -> id_stall=1 exactly 2 cycles, stall_cnt=2, then reg value.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: captures decoded operands, detects RAW hazards, forwards EX/MEM and MEM/WB results (ID_EX_FWD_EN).
// Latency: ID->EX one cycle; ex_opA/ex_opB and id_stall are combinational over the stored slot.
// Backpressure: ~ex_ready holds the slot (operands refreshed each hold cycle) and stalls ID; hazards insert bubbles.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_wen,
    input  logic          id_is_load,
    input  logic [DW-1:0] id_busX,
    input  logic [DW-1:0] id_busY,
    input  logic          flush,
    input  logic          ex_ready,
    input  logic [AW-1:0] exmem_rd,
    input  logic          exmem_wen,
    input  logic [DW-1:0] exmem_result,
    input  logic [AW-1:0] memwb_rd,
    input  logic          memwb_wen,
    input  logic [DW-1:0] memwb_result,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_opA,
    output logic [DW-1:0] ex_opB,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic          ex_wen,
    output logic          ex_is_load,
    output logic [31:0]   stall_cnt
);

    logic          r_ex_valid;
    logic [AW-1:0] r_ex_rs;
    logic [AW-1:0] r_ex_rt;
    logic [AW-1:0] r_ex_rd;
    logic          r_ex_wen;
    logic          r_ex_is_load;
    logic [DW-1:0] r_opA;
    logic [DW-1:0] r_opB;
    logic [31:0]   r_stall_cnt;

    logic          w_hold;
    logic          w_adv;
    logic          w_hazard_ld;
    logic          w_hazard_nf;
    logic          w_id_stall;
    logic          w_capture;
    logic [DW-1:0] w_opA;
    logic [DW-1:0] w_opB;

    // Register 0 never participates in a dependency.
    function automatic logic raw_hit(input logic used, input logic [AW-1:0] src,
                                     input logic [AW-1:0] dst);
        return used && (src != '0) && (src == dst);
    endfunction

    assign w_hold = r_ex_valid & ~ex_ready;
    assign w_adv  = ~w_hold;

    assign w_hazard_ld = r_ex_valid & r_ex_is_load & r_ex_wen &
                         (raw_hit(id_uses_rs, id_rs, r_ex_rd) |
                          raw_hit(id_uses_rt, id_rt, r_ex_rd));

`ifdef ID_EX_FWD_EN
    assign w_hazard_nf = 1'b0;

    always_comb begin
        w_opA = r_opA;
        if (r_ex_rs != '0 && exmem_wen && exmem_rd == r_ex_rs)
            w_opA = exmem_result;
        else if (r_ex_rs != '0 && memwb_wen && memwb_rd == r_ex_rs)
            w_opA = memwb_result;
    end

    always_comb begin
        w_opB = r_opB;
        if (r_ex_rt != '0 && exmem_wen && exmem_rd == r_ex_rt)
            w_opB = exmem_result;
        else if (r_ex_rt != '0 && memwb_wen && memwb_rd == r_ex_rt)
            w_opB = memwb_result;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_result, memwb_rd, memwb_wen, memwb_result};

    // MEM/WB producers are already covered by the register-file write bypass.
    assign w_hazard_nf = (r_ex_valid & r_ex_wen &
                          (raw_hit(id_uses_rs, id_rs, r_ex_rd) |
                           raw_hit(id_uses_rt, id_rt, r_ex_rd))) |
                         (exmem_wen &
                          (raw_hit(id_uses_rs, id_rs, exmem_rd) |
                           raw_hit(id_uses_rt, id_rt, exmem_rd)));

    assign w_opA = r_opA;
    assign w_opB = r_opB;
`endif

    assign w_id_stall = ~flush & id_valid & (w_hold | w_hazard_ld | w_hazard_nf);
    assign w_capture  = id_valid & ~w_id_stall & ~flush;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_wen     <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_opA        <= '0;
            r_opB        <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_adv) begin
                if (w_capture) begin
                    r_ex_valid   <= 1'b1;
                    r_ex_rs      <= id_rs;
                    r_ex_rt      <= id_rt;
                    r_ex_rd      <= id_rd;
                    r_ex_wen     <= id_wen;
                    r_ex_is_load <= id_is_load;
                    r_opA        <= id_busX;
                    r_opB        <= id_busY;
                end else begin
                    r_ex_valid <= 1'b0;
                    r_ex_wen   <= 1'b0;
                end
            end else begin
                // Latch forwarded values so they survive the producers retiring during the hold.
                r_opA <= w_opA;
                r_opB <= w_opB;
            end
            if (w_id_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign id_stall   = w_id_stall;
    assign ex_valid   = r_ex_valid;
    assign ex_opA     = w_opA;
    assign ex_opB     = w_opB;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_rd      = r_ex_rd;
    assign ex_wen     = r_ex_wen;
    assign ex_is_load = r_ex_is_load;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed hazard/forwarding scenarios followed by random traffic, checked against a transaction-level model.
module tb_id_ex_operand_stage;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt, id_wen, id_is_load;
    logic [DW-1:0] id_busX, id_busY;
    logic          flush, ex_ready;
    logic [AW-1:0] exmem_rd, memwb_rd;
    logic          exmem_wen, memwb_wen;
    logic [DW-1:0] exmem_result, memwb_result;
    logic          id_stall, ex_valid;
    logic [DW-1:0] ex_opA, ex_opB;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_wen, ex_is_load;
    logic [31:0]   stall_cnt;

    always #5 Clk = ~Clk;

    id_ex_operand_stage #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_busX(id_busX), .id_busY(id_busY), .flush(flush),
        .ex_ready(ex_ready), .exmem_rd(exmem_rd), .exmem_wen(exmem_wen),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_wen(memwb_wen),
        .memwb_result(memwb_result), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b0;

    // The instruction the model believes occupies EX.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs, rt, rd;
        logic          wen, ld;
        logic [DW-1:0] a, b;
    } slot_t;
    slot_t   m;
    longint  cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit id_reads(input logic [AW-1:0] r);
        return (r != 0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
    endfunction

    function automatic bit exp_stall();
        bit busy;
        if (flush || !id_valid) return 1'b0;
        busy = (m.v && !ex_ready) || (m.v && m.ld && m.wen && id_reads(m.rd));
        if (!FWD)
            busy = busy || (m.v && m.wen && id_reads(m.rd)) || (exmem_wen && id_reads(exmem_rd));
        return busy;
    endfunction

    // Youngest producer applied last so it overrides the older one.
    function automatic logic [DW-1:0] operand(input logic [AW-1:0] src, input logic [DW-1:0] kept);
        logic [DW-1:0] v;
        v = kept;
        if (FWD && src != 0 && memwb_wen && memwb_rd == src) v = memwb_result;
        if (FWD && src != 0 && exmem_wen && exmem_rd == src) v = exmem_result;
        return v;
    endfunction

    task automatic check_all();
        chk("stall", id_stall, exp_stall());
        chk("valid", ex_valid, m.v);
        chk("wen", ex_wen, m.wen);
        chk("cnt", stall_cnt, cnt);
        if (m.v) begin
            chk("opA", ex_opA, operand(m.rs, m.a));
            chk("opB", ex_opB, operand(m.rt, m.b));
            chk("rs", ex_rs, m.rs);
            chk("rt", ex_rt, m.rt);
            chk("rd", ex_rd, m.rd);
            chk("ld", ex_is_load, m.ld);
        end
    endtask

    task automatic tick();
        slot_t  n;
        longint nc;
        bit     st;
        #1;
        if (model_on) check_all();
        st = exp_stall();
        n  = m;
        nc = cnt;
        if (!rst) begin
            n  = '0;
            nc = 0;
        end else begin
            if (m.v && !ex_ready) begin
                n.a = operand(m.rs, m.a);
                n.b = operand(m.rt, m.b);
            end else if (id_valid && !st && !flush) begin
                n.v = 1'b1; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
                n.wen = id_wen; n.ld = id_is_load; n.a = id_busX; n.b = id_busY;
            end else begin
                n.v = 1'b0;
                n.wen = 1'b0;
            end
            if (st && nc < 64'hFFFF_FFFF) nc = nc + 1;
        end
        @(posedge Clk);
        #1;
        m   = n;
        cnt = nc;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_wen = 0; id_is_load = 0; id_busX = 0; id_busY = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic clear_pipe();
        exmem_rd = 0; exmem_wen = 0; exmem_result = 0;
        memwb_rd = 0; memwb_wen = 0; memwb_result = 0;
    endtask

    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic wen, input logic ld, input logic [DW-1:0] x, input logic [DW-1:0] y);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1; id_uses_rt = 1;
        id_wen = wen; id_is_load = ld; id_busX = x; id_busY = y;
    endtask

    logic [DW-1:0] exp_hold;

    initial begin
        m = '0;
        cnt = 0;
        rst = 0;
        idle();
        clear_pipe();
        issue(1, 2, 3, 1, 0, 'h11, 'h22);
        tick();
        tick();
        settle();
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_opA", ex_opA, 0);
        chk("rst_wen", ex_wen, 0);
        chk("rst_rd", ex_rd, 0);
        model_on = 1'b1;
        rst = 1;
        idle();

        // add r3,r1,r2 followed by sub r4,r3,r1
        issue(1, 2, 3, 1, 0, 'h10, 'h20);
        tick();
        issue(3, 1, 4, 1, 0, 'h999, 'h10);
        settle();
`ifdef ID_EX_FWD_EN
        chk("fwd_nostall", id_stall, 0);
        tick();
        idle();
        exmem_rd = 3; exmem_wen = 1; exmem_result = 'h55;
        settle();
        chk("fwd_valid", ex_valid, 1);
        chk("fwd_opA", ex_opA, 'h55);
        chk("fwd_opB", ex_opB, 'h10);
        chk("fwd_cnt", stall_cnt, 0);
`else
        chk("raw_stall1", id_stall, 1);
        tick();
        exmem_rd = 3; exmem_wen = 1; exmem_result = 'h55;
        settle();
        chk("raw_stall2", id_stall, 1);
        chk("raw_bubble", ex_valid, 0);
        tick();
        exmem_wen = 0; memwb_rd = 3; memwb_wen = 1; memwb_result = 'h55; id_busX = 'h55;
        settle();
        chk("raw_release", id_stall, 0);
        chk("raw_cnt", stall_cnt, 2);
        tick();
        idle();
        clear_pipe();
        settle();
        chk("raw_valid", ex_valid, 1);
        chk("raw_opA", ex_opA, 'h55);
`endif
        tick();
        clear_pipe();
        idle();
        tick();

        // lw r5 then a consumer of r5 on rt
        issue(1, 0, 5, 1, 1, 'h100, 0);
        tick();
        issue(2, 5, 6, 1, 0, 'h2, 'hDEAD);
        settle();
        chk("lu_stall", id_stall, 1);
        tick();
        exmem_rd = 5; exmem_wen = 1; exmem_result = 'h104;
        settle();
        chk("lu_bubble", ex_valid, 0);
`ifdef ID_EX_FWD_EN
        chk("lu_release", id_stall, 0);
        tick();
        idle();
        exmem_wen = 0; memwb_rd = 5; memwb_wen = 1; memwb_result = 'hA5A5;
        settle();
`else
        chk("lu_stall2", id_stall, 1);
        tick();
        exmem_wen = 0; memwb_rd = 5; memwb_wen = 1; memwb_result = 'hA5A5; id_busY = 'hA5A5;
        settle();
        chk("lu_release", id_stall, 0);
        tick();
        idle();
        clear_pipe();
        settle();
`endif
        chk("lu_valid", ex_valid, 1);
        chk("lu_opB", ex_opB, 'hA5A5);
        chk("lu_opA", ex_opA, 'h2);
        tick();
        clear_pipe();
        idle();
        tick();

        // three-cycle EX backpressure while r2's producer drains through EX/MEM and MEM/WB
        issue(2, 1, 7, 1, 0, 'h11, 'h1);
        tick();
        ex_ready = 0;
        exmem_rd = 2; exmem_wen = 1; exmem_result = 'h77;
        issue(6, 0, 8, 1, 0, 'h66, 0);
        settle();
        chk("hold_stall", id_stall, 1);
        tick();
        exmem_wen = 0; memwb_rd = 2; memwb_wen = 1; memwb_result = 'h77;
        tick();
        memwb_wen = 0;
        settle();
        chk("hold_valid", ex_valid, 1);
        chk("hold_rd", ex_rd, 7);
        tick();
        ex_ready = 1;
        settle();
        exp_hold = FWD ? 32'h77 : 32'h11;
        chk("hold_opA", ex_opA, exp_hold);
        chk("hold_release", id_stall, 0);
        tick();
        idle();
        settle();
        chk("hold_next_rd", ex_rd, 8);
        tick();

        // flush beats a load-use stall; flush never kills the held older instruction
        clear_pipe();
        issue(1, 0, 5, 1, 1, 0, 0);
        tick();
        issue(5, 0, 9, 1, 0, 0, 0);
        flush = 1;
        settle();
        chk("flush_stall", id_stall, 0);
        tick();
        idle();
        settle();
        chk("flush_bubble", ex_valid, 0);
        issue(1, 2, 10, 1, 0, 'h1, 'h2);
        tick();
        ex_ready = 0;
        issue(3, 3, 11, 1, 0, 0, 0);
        flush = 1;
        settle();
        chk("flush_hold_stall", id_stall, 0);
        tick();
        settle();
        chk("flush_keeps_old", ex_valid, 1);
        chk("flush_keeps_rd", ex_rd, 10);
        idle();
        tick();

        // r0 producers are never forwarded nor hazarded
        issue(0, 0, 0, 1, 0, 0, 0);
        tick();
        issue(0, 0, 12, 1, 0, 0, 0);
        exmem_rd = 0; exmem_wen = 1; exmem_result = 'hBAD;
        memwb_rd = 0; memwb_wen = 1; memwb_result = 'hBAD;
        settle();
        chk("r0_stall", id_stall, 0);
        chk("r0_opA", ex_opA, 0);
        chk("r0_opB", ex_opB, 0);
        tick();
        settle();
        chk("r0_next_opA", ex_opA, 0);
        clear_pipe();
        idle();
        tick();

        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(49) != 0);
            id_valid     = ($urandom_range(3) != 0);
            id_rs        = AW'($urandom_range(3));
            id_rt        = AW'($urandom_range(3));
            id_rd        = AW'($urandom_range(3));
            id_uses_rs   = $urandom_range(1) != 0;
            id_uses_rt   = $urandom_range(1) != 0;
            id_wen       = $urandom_range(1) != 0;
            id_is_load   = ($urandom_range(2) == 0);
            id_busX      = $urandom;
            id_busY      = $urandom;
            flush        = ($urandom_range(7) == 0);
            ex_ready     = ($urandom_range(3) != 0);
            exmem_rd     = AW'($urandom_range(3));
            exmem_wen    = $urandom_range(1) != 0;
            exmem_result = $urandom;
            memwb_rd     = AW'($urandom_range(3));
            memwb_wen    = $urandom_range(1) != 0;
            memwb_result = $urandom;
            tick();
        end
        rst = 1;
        idle();
        clear_pipe();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
